// File: rtl/debug_pkg.sv
// debug_pkg: constants and FSM states shared by the register dump, the debug unit and the host decoder
package debug_pkg;
   localparam int DBG_LEN_DATA = 32;
   localparam int DBG_NUM_REGS = 32;
   localparam int DBG_NUM_BITS = 5;
   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam int FRAME_WORDS_BASE = DBG_NUM_REGS + 1;
   localparam int FRAME_WORDS_CC = DBG_NUM_REGS + 2;
   localparam int FRAME_BYTES_BASE = 1 + (DBG_LEN_DATA / 8) * FRAME_WORDS_BASE;
   localparam int FRAME_BYTES_CC = 1 + (DBG_LEN_DATA / 8) * FRAME_WORDS_CC;
`ifdef DEBUG_CYCLE_COUNT_EN
   localparam int FRAME_WORDS = FRAME_WORDS_CC;
`else
   localparam int FRAME_WORDS = FRAME_WORDS_BASE;
`endif
   localparam int FRAME_BYTES = 1 + (DBG_LEN_DATA / 8) * FRAME_WORDS;
   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_WAIT_HDR, S_LOAD, S_SEND, S_WAIT, S_NEXT, S_FINISH
   } state_t;
endpackage

// File: rtl/word_serializer.sv
// word_serializer: loads one word and shifts it out MSB-first a byte at a time
module word_serializer #(
   parameter int LEN_DATA = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic                shift,
   input  logic [LEN_DATA-1:0] din,
   output logic [7:0]          nxt_byte,
   output logic                last_byte
);
   localparam int NB = LEN_DATA / 8;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   logic [LEN_DATA-1:0] shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d;
   // next shifter contents; nxt_byte lets the caller register the byte it is about to send
   always_comb begin
      shift_d = load ? din : shift ? shift_q << 8 : shift_q;
      cnt_d = load ? '0 : shift ? cnt_q + 1'b1 : cnt_q;
   end
   assign nxt_byte = shift_d[LEN_DATA-1 -: 8];
   assign last_byte = cnt_q == CW'(NB - 1);
   // shifter and byte counter state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_q <= '0;
         cnt_q <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/debug_recolector.sv
// debug_recolector: dumps PC and the register file to the UART as a byte frame (option DEBUG_CYCLE_COUNT_EN appends the cycle count)
module debug_recolector
   import debug_pkg::*;
#(
   parameter int LEN_DATA = 32,
   parameter int NUM_REGS = 32,
   parameter int NUM_BITS = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [LEN_DATA-1:0] in_pc,
   input  logic [LEN_DATA-1:0] in_reg_data,
   output logic [NUM_BITS-1:0] out_reg_addr,
   output logic [7:0]          tx_data,
   output logic                tx_start,
   input  logic                tx_done,
   output logic                busy,
   output logic                done
`ifdef DEBUG_CYCLE_COUNT_EN
   ,input logic [LEN_DATA-1:0] in_cycle_cnt
`endif
);
   localparam int WW = $clog2(NUM_REGS + 2);
`ifdef DEBUG_CYCLE_COUNT_EN
   localparam int LAST_W = NUM_REGS + 1;
`else
   localparam int LAST_W = NUM_REGS;
`endif
   state_t state_q, state_d;
   logic [WW-1:0] w_q, w_d;
   logic [LEN_DATA-1:0] pc_q, pc_d, word;
   logic [NUM_BITS-1:0] addr_q, addr_d;
   logic [7:0] tx_data_q, tx_data_d, nxt_byte;
   logic tx_start_q, tx_start_d, busy_q, busy_d, done_q, done_d, last_byte, hold;
`ifdef DEBUG_CYCLE_COUNT_EN
   logic [LEN_DATA-1:0] cyc_q, cyc_d;
   // word 0 is the PC, then the registers, then the captured cycle count
   always_comb word = (w_q == '0) ? pc_q : (w_q <= WW'(NUM_REGS)) ? in_reg_data : cyc_q;
`else
   // word 0 is the PC, then the registers
   always_comb word = (w_q == '0) ? pc_q : in_reg_data;
`endif
   word_serializer #(.LEN_DATA(LEN_DATA)) u_ser (
      .clk(clk),
      .reset(reset),
      .load(state_q == S_LOAD),
      .shift(state_q == S_WAIT && tx_done),
      .din(word),
      .nxt_byte(nxt_byte),
      .last_byte(last_byte)
   );
   // next state, word index and captures; outputs are derived from the next state so they stay Moore
   always_comb begin
      state_d = state_q;
      w_d = w_q;
      pc_d = pc_q;
`ifdef DEBUG_CYCLE_COUNT_EN
      cyc_d = cyc_q;
`endif
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_HDR;
            w_d = '0;
            pc_d = in_pc;
`ifdef DEBUG_CYCLE_COUNT_EN
            cyc_d = in_cycle_cnt;
`endif
         end
         S_HDR: state_d = S_WAIT_HDR;
         S_WAIT_HDR: state_d = tx_done ? S_LOAD : S_WAIT_HDR;
         S_LOAD: state_d = S_SEND;
         S_SEND: state_d = S_WAIT;
         S_WAIT: state_d = !tx_done ? S_WAIT : last_byte ? S_NEXT : S_SEND;
         S_NEXT: begin
            w_d = w_q + 1'b1;
            state_d = (w_q == WW'(LAST_W)) ? S_FINISH : S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
      hold = state_d inside {S_LOAD, S_SEND, S_WAIT, S_NEXT};
      addr_d = (hold && w_d != '0 && w_d <= WW'(NUM_REGS)) ? NUM_BITS'(w_d - 1'b1) : '0;
      tx_start_d = state_d == S_HDR || state_d == S_SEND;
      tx_data_d = state_d == S_HDR ? HDR_BYTE : state_d == S_SEND ? nxt_byte : 8'h00;
      busy_d = state_d != S_IDLE;
      done_d = state_d == S_FINISH;
   end
   // all FSM state and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         w_q <= '0;
         pc_q <= '0;
         addr_q <= '0;
         tx_data_q <= '0;
         tx_start_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef DEBUG_CYCLE_COUNT_EN
         cyc_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         w_q <= w_d;
         pc_q <= pc_d;
         addr_q <= addr_d;
         tx_data_q <= tx_data_d;
         tx_start_q <= tx_start_d;
         busy_q <= busy_d;
         done_q <= done_d;
`ifdef DEBUG_CYCLE_COUNT_EN
         cyc_q <= cyc_d;
`endif
      end
   end
   assign out_reg_addr = addr_q;
   assign tx_data = tx_data_q;
   assign tx_start = tx_start_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule
